// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding, defaults and round-robin helper for the UART TX arbiter
package uart_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    localparam int DBIT_DEFAULT = 8;
    localparam int RR_MAX       = 8;

    // Loop form of the round-robin pick: first set bit of req scanning upward
    // from ptr+1 with wrap at n. Returns one-hot, zero when req is empty.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input logic [2:0]        ptr,
                                                  input int                n);
        logic [RR_MAX-1:0] oh;
        int                idx;
        oh = '0;
        for (int k = 1; k <= RR_MAX; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k <= n && oh == '0 && req[idx[2:0]]) begin
                oh[idx[2:0]] = 1'b1;
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_priority.sv
// rtl/rr_priority.sv - combinational round-robin priority picker (rotate, priority-encode, rotate back)
//   req_i : N_REQ request vector
//   ptr_i : index of the last owner; it gets lowest priority
//   gnt_o : one-hot winner, zero when no request
module rr_priority #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] ptr_i,
    output logic [N_REQ-1:0]         gnt_o
);

    localparam int PW = $clog2(N_REQ);

    logic [PW:0]      shamt;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first_oh;

    always_comb begin
        // Rotate so that requester ptr+1 sits at bit 0; shamt may equal N_REQ.
        shamt    = {1'b0, ptr_i} + (PW + 1)'(1);
        rot      = N_REQ'({req_i, req_i} >> shamt);
        // Isolate the lowest set bit.
        first_oh = rot & (~rot + N_REQ'(1));
        // Rotate back into requester numbering.
        gnt_o    = N_REQ'(({first_oh, first_oh} << shamt) >> N_REQ);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet-locked arbiter sharing one UART transmitter
//   clk, rst          : clock, synchronous active-high reset
//   req/valid/last    : per-requester packet request, byte valid, end-of-packet
//   data              : flattened bytes, requester i at [i*DBIT +: DBIT]
//   ready             : byte of requester i accepted this cycle
//   grant, busy       : registered one-hot owner, grant held
//   timeout           : one-cycle pulse when the owner is dropped for idling
//   tx_full           : UART TX FIFO full
//   wr_uart, w_data   : UART write strobe and byte
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      valid,
    input  logic [N_REQ-1:0]      last,
    input  logic [N_REQ*DBIT-1:0] data,
    output logic [N_REQ-1:0]      ready,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic                  timeout,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [DBIT-1:0]       w_data
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] pick;
    logic [PW-1:0]    g_idx;
    logic             req_g, valid_g, last_g, accept, idle_hit;

    rr_priority #(.N_REQ(N_REQ)) u_rr (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick)
    );

    // Owner view; grant_q is zero in IDLE so w_data and accept fall to 0 there.
    always_comb begin
        g_idx  = '0;
        w_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx  = PW'(i);
                w_data = data[i*DBIT +: DBIT];
            end
        end
        req_g    = |(req & grant_q);
        valid_g  = |(valid & grant_q);
        last_g   = |(last & grant_q);
        accept   = valid_g & ~tx_full;
        // Only idle cycles advance the counter, so a tx_full stall never trips it.
        idle_hit = ~valid_g & (cnt_q == CW'(TIMEOUT - 1));
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (accept) begin
                    cnt_d = '0;
                end else if (!valid_g) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if ((accept && last_g) || !req_g || idle_hit) begin
                    state_d   = ST_IDLE;
                    grant_d   = '0;
                    ptr_d     = g_idx;
                    cnt_d     = '0;
                    // An abandoning owner is a plain release, not a timeout.
                    timeout_d = idle_hit & req_g;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            ptr_q     <= PW'(N_REQ - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ready   = accept ? grant_q : '0;
    assign wr_uart = accept;
    assign grant   = grant_q;
    assign busy    = (state_q == ST_LOCK);
    assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 1023;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, valid, last;
    logic [N*DB-1:0] data;
    logic            tx_full;
    logic [N-1:0]    ready, grant;
    logic            busy, timeout, wr_uart;
    logic [DB-1:0]   w_data;

    uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .valid   (valid),
        .last    (last),
        .data    (data),
        .ready   (ready),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout),
        .tx_full (tx_full),
        .wr_uart (wr_uart),
        .w_data  (w_data)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: owner index (-1 = none), last owner, idle-cycle count.
    int m_owner = -1;
    int m_ptr   = N - 1;
    int m_idle  = 0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin : ref_model
        int o, p, idl;
        bit t, acc, rel;
        o = m_owner; p = m_ptr; idl = m_idle; t = 1'b0; rel = 1'b0;
        if (rst) begin
            o = -1; p = N - 1; idl = 0;
        end else if (o < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (o < 0 && req[(p + k) % N]) begin
                    o = (p + k) % N;
                    idl = 0;
                end
            end
        end else begin
            acc = valid[o] && !tx_full;
            if ((acc && last[o]) || !req[o]) rel = 1'b1;
            else if (acc) idl = 0;
            else if (!valid[o]) begin
                idl++;
                if (idl == TO) begin rel = 1'b1; t = 1'b1; end
            end
            if (rel) begin p = o; o = -1; idl = 0; end
        end
        m_owner <= o; m_ptr <= p; m_idle <= idl; m_to <= t;
    end

    always @(negedge clk) begin : ref_check
        logic [N-1:0]  eg;
        logic [DB-1:0] ed;
        bit            acc;
        if (chk_en) begin
            eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
            acc = (m_owner >= 0) && valid[m_owner] && !tx_full;
            ed  = (m_owner >= 0) ? DB'(data >> (m_owner * DB)) : '0;
            chk("mdl_grant", grant, eg);
            chk("mdl_ready", ready, acc ? eg : '0);
            chk("mdl_wr", wr_uart, acc);
            chk("mdl_wdata", w_data, ed);
            chk("mdl_busy", busy, m_owner >= 0);
            chk("mdl_timeout", timeout, m_to);
        end
    end

    typedef struct {
        logic            rst;
        logic [N-1:0]    req, valid, last;
        logic [N*DB-1:0] data;
        logic            tx_full;
        logic [N-1:0]    e_grant, e_ready;
        logic            e_wr;
        logic [DB-1:0]   e_wdata;
        logic            e_busy, e_to;
    } vec_t;

    vec_t        tbl[7];
    int          wc[$];
    logic [7:0]  wd[$];
    int          n_wr, n_to, to_at;
    logic [N-1:0] g_at;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; valid = '0; last = '0; data = '0; tx_full = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; valid = '0; last = '0; data = '0; tx_full = 1'b0;
        step();
        chk_en = 1'b1;

        // Reset state, then a 3-byte packet from requester 0.
        tbl[0] = '{1'b1, 4'h0, 4'h0, 4'h0, 32'h0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 4'h1, 4'h0, 4'h0, 32'h0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 4'h1, 4'h1, 4'h0, 32'h41, 1'b0, 4'h1, 4'h1, 1'b1, 8'h41, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 4'h1, 4'h1, 4'h0, 32'h42, 1'b0, 4'h1, 4'h1, 1'b1, 8'h42, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 4'h1, 4'h1, 4'h1, 32'h43, 1'b0, 4'h1, 4'h1, 1'b1, 8'h43, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 4'h0, 4'h0, 4'h0, 32'h0,  1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            rst = tbl[i].rst; req = tbl[i].req; valid = tbl[i].valid;
            last = tbl[i].last; data = tbl[i].data; tx_full = tbl[i].tx_full;
            #1;
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].e_grant);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].e_ready);
            chk($sformatf("tbl%0d_wr", i), wr_uart, tbl[i].e_wr);
            chk($sformatf("tbl%0d_wdata", i), w_data, tbl[i].e_wdata);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_timeout", i), timeout, tbl[i].e_to);
            step();
        end

        // All four requesting, 1-byte packets: order 0,1,2,3,0, two cycles apart.
        do_reset();
        req = 4'hF; valid = 4'hF; last = 4'hF; data = 32'hA3A2A1A0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (wr_uart) begin wc.push_back(c); wd.push_back(w_data); end
            step();
        end
        chk("rr_count", wc.size(), 5);
        for (int j = 0; j < wc.size() && j < 5; j++) chk($sformatf("rr_byte%0d", j), wd[j], 8'hA0 + 8'(j % 4));
        for (int j = 1; j < wc.size(); j++) chk($sformatf("rr_gap%0d", j), wc[j] - wc[j-1], 2);

        // Requester 1 stalled by tx_full for 2000 cycles: no timeout, no write.
        do_reset();
        req = 4'h2; valid = 4'h2; last = 4'h2; data = 32'h0000_9900; tx_full = 1'b1;
        step();
        chk("stall_grant", grant, 4'h2);
        n_wr = 0; n_to = 0;
        for (int c = 0; c < 2000; c++) begin
            #1;
            if (wr_uart) n_wr++;
            if (timeout) n_to++;
            step();
        end
        chk("stall_writes", n_wr, 0);
        chk("stall_timeouts", n_to, 0);
        tx_full = 1'b0;
        #1;
        chk("stall_release_wr", wr_uart, 1'b1);
        chk("stall_release_data", w_data, 8'h99);
        step();
        req = '0; valid = '0; last = '0;
        #1;
        chk("stall_after_grant", grant, 4'h0);

        // Requester 2 idles until timeout; pending requester 3 wins next.
        do_reset();
        req = 4'h4;
        step();
        chk("to_grant", grant, 4'h4);
        req = 4'hC;
        to_at = -1; g_at = 'x;
        for (int off = 0; off < 1100; off++) begin
            #1;
            if (timeout) begin to_at = off; g_at = grant; break; end
            step();
        end
        chk("to_cycle", to_at, 1023);
        chk("to_grant_dropped", g_at, 4'h0);
        step();
        chk("to_one_pulse", timeout, 1'b0);
        chk("to_next_owner", grant, 4'h8);
        req = '0;
        step();
        step();

        // Requester 0 drops req while presenting 0x55; requester 1 waits its turn.
        do_reset();
        req = 4'h3; valid = 4'h3; data = 32'h0000_6655;
        step();
        req = 4'h2;
        #1;
        chk("drop_grant", grant, 4'h1);
        chk("drop_wr", wr_uart, 1'b1);
        chk("drop_data", w_data, 8'h55);
        step();
        chk("drop_released", grant, 4'h0);
        chk("drop_no_early_byte", wr_uart, 1'b0);
        step();
        chk("drop_next_grant", grant, 4'h2);
        chk("drop_next_data", w_data, 8'h66);
        req = '0; valid = '0;
        step();
        step();

        // Reset during the second byte of a 4-byte packet from requester 2.
        do_reset();
        req = 4'h4; valid = 4'h4; data = 32'h00B1_0000;
        step();
        #1;
        chk("rst_first_byte", w_data, 8'hB1);
        step();
        data = 32'h00B2_0000; rst = 1'b1;
        step();
        rst = 1'b0; req = 4'h5; valid = 4'h5; data = 32'h00B3_00C0;
        #1;
        chk("rst_grant", grant, 4'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wr", wr_uart, 1'b0);
        step();
        chk("rst_restart_grant", grant, 4'h1);
        chk("rst_restart_data", w_data, 8'hC0);
        req = '0; valid = '0;
        step();
        step();

        // Randomised traffic checked against the reference model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) req[i] = ~req[i];
            valid   = 4'($urandom);
            last    = 4'($urandom) & 4'($urandom);
            data    = $urandom;
            tx_full = ($urandom_range(0, 4) == 0);
            rst     = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; req = '0; valid = '0; last = '0; tx_full = 1'b0;
        step();
        step();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
